// File: rtl/add_pipe_if.sv
`default_nettype none
// ============================================================================
// add_pipe_if : operand/result handshake bundle for add_pipe   | rev 1.0
// ============================================================================
interface add_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] a;
  logic [19:0] b;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] s;
  logic        co;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, co
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, co
  );
endinterface
`default_nettype wire

// File: rtl/add_pipe.sv
`default_nettype none
// ============================================================================
// add_pipe : two-stage 20-bit carry-select adder with valid/ready flow control
// rev 1.0
// ============================================================================
module add_pipe (
  input  logic       clk,
  input  logic       rst,
  add_pipe_if.slave  bus
);
  localparam int c_NHI = 3;   // upper blocks B2..B4 precomputed in stage 1

  logic r_v1;
  logic r_v2;
  logic w_adv1;
  logic w_adv2;
  logic w_acc;

  assign w_adv2       = !r_v2 || bus.out_ready;
  assign w_adv1       = !r_v1 || w_adv2;
  assign w_acc        = bus.in_valid && w_adv1;
  assign bus.in_ready = w_adv1;
  assign bus.out_valid = r_v2;

  // Stage 1 combinational: ripple B0, carry-select B1, both variants of B2..B4
  logic [4:0] w_b0;
  logic [4:0] w_b1_c0;
  logic [4:0] w_b1_c1;
  logic [4:0] w_b1;
  logic [c_NHI-1:0][4:0] w_pre0;
  logic [c_NHI-1:0][4:0] w_pre1;

  assign w_b0    = {1'b0, bus.a[3:0]} + {1'b0, bus.b[3:0]} + {4'b0000, bus.ci};
  assign w_b1_c0 = {1'b0, bus.a[7:4]} + {1'b0, bus.b[7:4]};
  assign w_b1_c1 = {1'b0, bus.a[7:4]} + {1'b0, bus.b[7:4]} + 5'd1;
  assign w_b1    = w_b0[4] ? w_b1_c1 : w_b1_c0;

  for (genvar gi = 0; gi < c_NHI; gi++) begin : g_blk
    assign w_pre0[gi] = {1'b0, bus.a[4*(gi+2) +: 4]} + {1'b0, bus.b[4*(gi+2) +: 4]};
    assign w_pre1[gi] = {1'b0, bus.a[4*(gi+2) +: 4]} + {1'b0, bus.b[4*(gi+2) +: 4]} + 5'd1;
  end

  logic [7:0]            r_s1_lo;
  logic                  r_c2;
  logic [c_NHI-1:0][4:0] r_p0;
  logic [c_NHI-1:0][4:0] r_p1;

  // Stage 2 combinational: carry ripples through the precomputed selections
  logic [4:0] w_b2;
  logic [4:0] w_b3;
  logic [4:0] w_b4;

  assign w_b2 = r_c2    ? r_p1[0] : r_p0[0];
  assign w_b3 = w_b2[4] ? r_p1[1] : r_p0[1];
  assign w_b4 = w_b3[4] ? r_p1[2] : r_p0[2];

  logic [7:0]  r_s_lo;
  logic [11:0] r_s_hi;
  logic        r_co;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_s1_lo <= '0;
      r_c2    <= 1'b0;
      r_p0    <= '0;
      r_p1    <= '0;
      r_s_lo  <= '0;
      r_s_hi  <= '0;
      r_co    <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_v2 <= r_v1;
      end
      // Output registers only move when a real result replaces them
      if (w_adv2 && r_v1) begin
        r_s_lo <= r_s1_lo;
        r_s_hi <= {w_b4[3:0], w_b3[3:0], w_b2[3:0]};
        r_co   <= w_b4[4];
      end
      if (w_adv1) begin
        r_v1 <= w_acc;
      end
      if (w_acc) begin
        r_s1_lo <= {w_b1[3:0], w_b0[3:0]};
        r_c2    <= w_b1[4];
        r_p0    <= w_pre0;
        r_p1    <= w_pre1;
      end
    end
  end

  assign bus.s  = {r_s_hi, r_s_lo};
  assign bus.co = r_co;

endmodule
`default_nettype wire

// File: tb/tb_add_pipe.sv
`default_nettype none
// ============================================================================
// tb_add_pipe : directed + random scoreboard bench for add_pipe   | rev 1.0
// ============================================================================
module tb_add_pipe;
  logic clk;
  logic rst;

  add_pipe_if bus ();

  add_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] sum;
    int          acc;
  } item_t;

  item_t       q[$];
  int          cyc;
  int          n_chk;
  int          n_fail;
  logic        hold_chk;
  logic [20:0] held;

  task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [19:0] av, input logic [19:0] bv,
                       input logic civ, input logic ordy);
    bus.in_valid  = iv;
    bus.a         = av;
    bus.b         = bv;
    bus.ci        = civ;
    bus.out_ready = ordy;
  endtask

  // One clock: score the cycle at the falling edge, then take the rising edge.
  // Reference: a result is visible from the second edge after its accept, and
  // a set can be taken whenever fewer than two sets are held or one is leaving.
  task automatic tick();
    item_t it;
    @(negedge clk);
    if (rst) begin
      q.delete();
      hold_chk = 1'b0;
    end else begin
      chk("in_ready", {20'b0, bus.in_ready},
          {20'b0, (q.size() < 2) || bus.out_ready});
      chk("out_valid", {20'b0, bus.out_valid},
          {20'b0, (q.size() > 0) && (q[0].acc + 2 <= cyc)});
      if (hold_chk) chk("hold", {bus.co, bus.s}, held);
      hold_chk = bus.out_valid && !bus.out_ready;
      held     = {bus.co, bus.s};
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        chk("sum", {bus.co, bus.s}, q[0].sum);
        void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        it.sum = {1'b0, bus.a} + {1'b0, bus.b} + {20'b0, bus.ci};
        it.acc = cyc;
        q.push_back(it);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    chk("drained", 21'(q.size()), 21'd0);
    tick();
  endtask

  logic [19:0] ra;
  logic [19:0] rb;
  logic [19:0] set_a[1:3];
  logic [19:0] set_b[1:3];
  int          idx;
  logic        took;

  initial begin
    cyc      = 0;
    n_chk    = 0;
    n_fail   = 0;
    hold_chk = 1'b0;
    held     = '0;
    drive(1'b1, 20'hFFFFF, 20'hFFFFF, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_s", {1'b0, bus.s}, 21'd0);
    chk("rst_co", {20'b0, bus.co}, 21'd0);
    chk("rst_ov", {20'b0, bus.out_valid}, 21'd0);
    chk("rst_ir", {20'b0, bus.in_ready}, 21'd1);

    // Single add
    drive(1'b1, 20'h12345, 20'h0ABCD, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("single_ov", {20'b0, bus.out_valid}, 21'd1);
    chk("single_sum", {bus.co, bus.s}, {1'b0, 20'h1CF12});
    drain();

    // Full carry chains
    drive(1'b1, 20'hFFFFF, 20'h00000, 1'b1, 1'b1);
    tick();
    drive(1'b1, 20'hFFFFF, 20'hFFFFF, 1'b1, 1'b1);
    tick();
    chk("chain1", {bus.co, bus.s}, {1'b1, 20'h00000});
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    chk("chain2", {bus.co, bus.s}, {1'b1, 20'hFFFFF});
    drain();

    // Streaming back-to-back
    for (int i = 0; i < 1000; i++) begin
      ra = 20'($urandom);
      rb = 20'($urandom);
      drive(1'b1, ra, rb, 1'($urandom), 1'b1);
      tick();
    end
    drain();

    // Backpressure with three queued sets
    for (int i = 1; i <= 3; i++) begin
      set_a[i] = 20'($urandom);
      set_b[i] = 20'($urandom);
    end
    idx = 1;
    for (int i = 0; i < 5; i++) begin
      took = bus.in_ready;
      drive(1'b1, set_a[idx], set_b[idx], 1'b0, 1'b0);
      tick();
      if (took && idx < 3) idx++;
    end
    chk("bp_accepted", 21'(idx), 21'd3);
    chk("bp_full", {20'b0, bus.in_ready}, 21'd0);
    while (idx <= 3) begin
      took = bus.in_ready;
      drive(1'b1, set_a[idx], set_b[idx], 1'b0, 1'b1);
      tick();
      if (took) idx++;
      if (cyc > 90000) break;
    end
    drain();

    // Reset with both stages occupied
    for (int i = 0; i < 3; i++) begin
      ra = 20'($urandom);
      rb = 20'($urandom);
      drive(1'b1, ra, rb, 1'b1, 1'b0);
      tick();
    end
    chk("mid_full", {20'b0, bus.in_ready}, 21'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    chk("mid_ov", {20'b0, bus.out_valid}, 21'd0);
    chk("mid_ir", {20'b0, bus.in_ready}, 21'd1);
    chk("mid_s", {bus.co, bus.s}, 21'd0);
    for (int i = 0; i < 4; i++) tick();

    // Random stalls on both sides
    for (int i = 0; i < 10000; i++) begin
      ra = 20'($urandom);
      rb = 20'($urandom);
      drive(1'($urandom), ra, rb, 1'($urandom), 1'($urandom));
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
